// File: rtl/branch_sequencer_if.sv
// Handshake/bus bundle between branch_sequencer and its fetch, decode/branch
// and completion neighbours. The slave modport is the sequencer's view.
interface branch_sequencer_if;
  logic        i_BranchSeq_pause;
  logic        i_BranchSeq_fetchAck;
  logic        i_BranchSeq_decValid;
  logic [3:0]  i_BranchSeq_BRop;
  logic [31:0] i_BranchSeq_nextPc;
  logic        i_BranchSeq_retire;
  logic [31:0] o_BranchSeq_pc;
  logic        o_BranchSeq_fetchReq;
  logic        o_BranchSeq_flush;
  logic [1:0]  o_BranchSeq_state;
  logic        o_BranchSeq_decErr;
  logic [15:0] o_BranchSeq_brCnt;
  logic [15:0] o_BranchSeq_takenCnt;

  modport slave (
    input  i_BranchSeq_pause, i_BranchSeq_fetchAck, i_BranchSeq_decValid,
    input  i_BranchSeq_BRop, i_BranchSeq_nextPc, i_BranchSeq_retire,
    output o_BranchSeq_pc, o_BranchSeq_fetchReq, o_BranchSeq_flush,
    output o_BranchSeq_state, o_BranchSeq_decErr,
    output o_BranchSeq_brCnt, o_BranchSeq_takenCnt
  );

  modport master (
    output i_BranchSeq_pause, i_BranchSeq_fetchAck, i_BranchSeq_decValid,
    output i_BranchSeq_BRop, i_BranchSeq_nextPc, i_BranchSeq_retire,
    input  o_BranchSeq_pc, o_BranchSeq_fetchReq, o_BranchSeq_flush,
    input  o_BranchSeq_state, o_BranchSeq_decErr,
    input  o_BranchSeq_brCnt, o_BranchSeq_takenCnt
  );
endinterface

// File: rtl/branch_sequencer.sv
// Multicycle PC sequencer: FETCH -> DECODE -> RESOLVE -> WAIT, commits next-PC at retire.
// Branch/redirect statistics counters are built only when BRANCH_SEQ_STATS_EN is defined.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEC_TIMEOUT = 8
) (
  input  logic                i_BranchSeq_clk,
  input  logic                i_BranchSeq_rstn,
  branch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_RESOLVE = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  localparam int CW = $clog2(DEC_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(DEC_TIMEOUT);

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_tgt;
  logic          r_redir;
  logic          r_fetchReq;
  logic          r_flush;
  logic          r_decErr;
  logic [CW-1:0] r_decCnt;

  logic [31:0]   w_pcInc;
  logic [31:0]   w_tgt;
  logic          w_run;
  logic          w_commit;
  logic          w_resolve;

  // pc+4 wraps naturally in 32 bits; target is always word aligned
  assign w_pcInc   = r_pc + 32'd4;
  assign w_tgt     = bus.i_BranchSeq_nextPc & 32'hFFFF_FFFC;
  assign w_run     = !bus.i_BranchSeq_pause;
  assign w_commit  = w_run && (r_state == S_WAIT) && bus.i_BranchSeq_retire;
  assign w_resolve = w_run && (r_state == S_RESOLVE);

  always_ff @(posedge i_BranchSeq_clk) begin
    if (!i_BranchSeq_rstn) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_tgt      <= '0;
      r_redir    <= 1'b0;
      r_fetchReq <= 1'b0;
      r_flush    <= 1'b0;
      r_decErr   <= 1'b0;
      r_decCnt   <= '0;
    end else if (!w_run) begin
      r_fetchReq <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (bus.i_BranchSeq_fetchAck) begin
            r_state    <= S_DECODE;
            r_fetchReq <= 1'b0;
          end else begin
            r_fetchReq <= 1'b1;
          end
        end
        S_DECODE: begin
          r_fetchReq <= 1'b0;
          if (bus.i_BranchSeq_decValid) begin
            r_state  <= S_RESOLVE;
            r_decCnt <= '0;
          end else begin
            // counter saturates at the limit; the error flag is sticky
            if (r_decCnt != TMO)
              r_decCnt <= r_decCnt + 1'b1;
            if (r_decCnt >= TMO - 1'b1)
              r_decErr <= 1'b1;
          end
        end
        S_RESOLVE: begin
          r_fetchReq <= 1'b0;
          r_tgt      <= w_tgt;
          r_redir    <= (w_tgt != w_pcInc);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_fetchReq <= 1'b0;
          if (bus.i_BranchSeq_retire) begin
            r_pc    <= r_tgt;
            r_flush <= r_redir;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

`ifdef BRANCH_SEQ_STATS_EN
  logic        r_isBr;
  logic [15:0] r_brCnt;
  logic [15:0] r_takenCnt;

  always_ff @(posedge i_BranchSeq_clk) begin
    if (!i_BranchSeq_rstn) begin
      r_isBr     <= 1'b0;
      r_brCnt    <= '0;
      r_takenCnt <= '0;
    end else begin
      if (w_resolve)
        r_isBr <= (bus.i_BranchSeq_BRop == 4'b0010) ||
                  (bus.i_BranchSeq_BRop == 4'b0100) ||
                  (bus.i_BranchSeq_BRop == 4'b0001);
      if (w_commit && r_isBr && (r_brCnt != 16'hFFFF))
        r_brCnt <= r_brCnt + 16'd1;
      if (w_commit && r_redir && (r_takenCnt != 16'hFFFF))
        r_takenCnt <= r_takenCnt + 16'd1;
    end
  end

  assign bus.o_BranchSeq_brCnt    = r_brCnt;
  assign bus.o_BranchSeq_takenCnt = r_takenCnt;
`else
  logic w_unusedStats;
  assign w_unusedStats = w_commit ^ w_resolve ^ (^bus.i_BranchSeq_BRop);
  assign bus.o_BranchSeq_brCnt    = 16'h0000;
  assign bus.o_BranchSeq_takenCnt = 16'h0000;
`endif

  assign bus.o_BranchSeq_pc       = r_pc;
  assign bus.o_BranchSeq_fetchReq = r_fetchReq;
  assign bus.o_BranchSeq_flush    = r_flush;
  assign bus.o_BranchSeq_state    = r_state;
  assign bus.o_BranchSeq_decErr   = r_decErr;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: scoreboard of expected commits, immediate assertions.
module tb_branch_sequencer;

  logic clk;
  logic rstn;
  branch_sequencer_if bif ();

  branch_sequencer #(.RESET_PC(32'h0000_0000), .DEC_TIMEOUT(8)) dut (
    .i_BranchSeq_clk  (clk),
    .i_BranchSeq_rstn (rstn),
    .bus              (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_br  = 0;
  int          m_tk  = 0;
  logic [3:0]  cur_brop;
  logic [31:0] cur_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef BRANCH_SEQ_STATS_EN
    chk({tag, "_brCnt"},    {16'h0, bif.o_BranchSeq_brCnt},    32'(m_br));
    chk({tag, "_takenCnt"}, {16'h0, bif.o_BranchSeq_takenCnt}, 32'(m_tk));
`else
    chk({tag, "_brCnt"},    {16'h0, bif.o_BranchSeq_brCnt},    32'h0);
    chk({tag, "_takenCnt"}, {16'h0, bif.o_BranchSeq_takenCnt}, 32'h0);
`endif
  endtask

  // Drive one instruction from FETCH up to WAIT
  task automatic to_wait(input logic [3:0] brop, input logic [31:0] npc);
    for (int i = 0; i < 10 && !bif.o_BranchSeq_fetchReq; i++) tick();
    chk("fetchReq_up", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h1);
    bif.i_BranchSeq_fetchAck = 1'b1;
    tick();
    bif.i_BranchSeq_fetchAck = 1'b0;
    chk("st_decode", {30'h0, bif.o_BranchSeq_state}, 32'd1);
    chk("fetchReq_drop", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h0);
    bif.i_BranchSeq_decValid = 1'b1;
    bif.i_BranchSeq_BRop     = brop;
    bif.i_BranchSeq_nextPc   = npc;
    tick();
    bif.i_BranchSeq_decValid = 1'b0;
    chk("st_resolve", {30'h0, bif.o_BranchSeq_state}, 32'd2);
    tick();
    bif.i_BranchSeq_BRop   = 4'h0;
    bif.i_BranchSeq_nextPc = 32'hDEAD_BEEF;
    chk("st_wait", {30'h0, bif.o_BranchSeq_state}, 32'd3);
    chk("pc_hold_wait", bif.o_BranchSeq_pc, cur_pc);
    cur_brop = brop;
  endtask

  // Retire the instruction in WAIT; retire is held an extra cycle to prove single commit
  task automatic commit(input logic [31:0] exp_pc, input logic exp_flush);
    exp_t e;
    sb.push_back('{pc: exp_pc, flush: exp_flush});
    if (cur_brop == 4'b0010 || cur_brop == 4'b0100 || cur_brop == 4'b0001) m_br++;
    if (exp_flush) m_tk++;
    bif.i_BranchSeq_retire = 1'b1;
    tick();
    chk("st_fetch", {30'h0, bif.o_BranchSeq_state}, 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk("commit_pc",    bif.o_BranchSeq_pc, e.pc);
      chk("commit_flush", {31'h0, bif.o_BranchSeq_flush}, {31'h0, e.flush});
    end
    chk("fetchReq_entry", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h0);
    chk_cnt("commit");
    cur_pc = exp_pc;
    tick();
    bif.i_BranchSeq_retire = 1'b0;
    chk("flush_1cyc",   {31'h0, bif.o_BranchSeq_flush}, 32'h0);
    chk("single_commit", bif.o_BranchSeq_pc, cur_pc);
    chk("fetchReq_next", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},       bif.o_BranchSeq_pc, 32'h0);
    chk({tag, "_state"},    {30'h0, bif.o_BranchSeq_state}, 32'd0);
    chk({tag, "_fetchReq"}, {31'h0, bif.o_BranchSeq_fetchReq}, 32'h0);
    chk({tag, "_flush"},    {31'h0, bif.o_BranchSeq_flush}, 32'h0);
    chk({tag, "_decErr"},   {31'h0, bif.o_BranchSeq_decErr}, 32'h0);
    chk_cnt(tag);
  endtask

  initial begin
    rstn                     = 1'b0;
    bif.i_BranchSeq_pause    = 1'b0;
    bif.i_BranchSeq_fetchAck = 1'b0;
    bif.i_BranchSeq_decValid = 1'b0;
    bif.i_BranchSeq_BRop     = 4'h0;
    bif.i_BranchSeq_nextPc   = 32'h0;
    bif.i_BranchSeq_retire   = 1'b0;
    cur_pc   = 32'h0;
    cur_brop = 4'h0;

    // reset, then sequential flow 0 -> 4 -> 8 -> C -> 10
    tick(); tick();
    chk_reset("rst");
    rstn = 1'b1;
    tick();
    chk("rst_fetchReq_up", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      to_wait(4'b0000, cur_pc + 32'd4);
      commit(cur_pc + 32'd4, 1'b0);
    end

    // taken beq at 0x10
    to_wait(4'b0100, 32'h0000_0040);
    commit(32'h0000_0040, 1'b1);
    // jump back to 0x10, untaken bne, then jump with misaligned target
    to_wait(4'b0010, 32'h0000_0010);
    commit(32'h0000_0010, 1'b1);
    to_wait(4'b0001, 32'h0000_0014);
    commit(32'h0000_0014, 1'b0);
    to_wait(4'b0010, 32'h0000_0103);
    commit(32'h0000_0100, 1'b1);

    // pause in WAIT with retire high
    to_wait(4'b0000, 32'h0000_0104);
    bif.i_BranchSeq_pause  = 1'b1;
    bif.i_BranchSeq_retire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pause_state",    {30'h0, bif.o_BranchSeq_state}, 32'd3);
      chk("pause_pc",       bif.o_BranchSeq_pc, 32'h0000_0100);
      chk("pause_fetchReq", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h0);
      chk("pause_flush",    {31'h0, bif.o_BranchSeq_flush}, 32'h0);
    end
    bif.i_BranchSeq_pause = 1'b0;
    commit(32'h0000_0104, 1'b0);
    bif.i_BranchSeq_pause = 1'b1;
    tick();
    chk("pause_fetch_req", {31'h0, bif.o_BranchSeq_fetchReq}, 32'h0);
    chk("pause_fetch_st",  {30'h0, bif.o_BranchSeq_state}, 32'd0);
    bif.i_BranchSeq_pause = 1'b0;

    // non-branch redirect to top of memory, then wrap to 0
    to_wait(4'b0000, 32'hFFFF_FFFC);
    commit(32'hFFFF_FFFC, 1'b1);
    to_wait(4'b0000, 32'h0000_0000);
    commit(32'h0000_0000, 1'b0);

    // decode timeout
    for (int i = 0; i < 10 && !bif.o_BranchSeq_fetchReq; i++) tick();
    bif.i_BranchSeq_fetchAck = 1'b1;
    tick();
    bif.i_BranchSeq_fetchAck = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("tmo_state",  {30'h0, bif.o_BranchSeq_state}, 32'd1);
      chk("tmo_decErr", {31'h0, bif.o_BranchSeq_decErr}, (k == 8) ? 32'h1 : 32'h0);
    end
    bif.i_BranchSeq_decValid = 1'b1;
    bif.i_BranchSeq_nextPc   = 32'h0000_0004;
    tick();
    bif.i_BranchSeq_decValid = 1'b0;
    tick();
    cur_brop = 4'h0;
    commit(32'h0000_0004, 1'b0);
    chk("decErr_sticky", {31'h0, bif.o_BranchSeq_decErr}, 32'h1);

    rstn = 1'b0;
    tick(); tick();
    m_br = 0;
    m_tk = 0;
    cur_pc = 32'h0;
    chk_reset("rst2");
    rstn = 1'b1;
    tick();

    // reset mid-WAIT with a redirect latched
    to_wait(4'b0010, 32'h0000_0080);
    bif.i_BranchSeq_retire = 1'b1;
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_reset("rst_wait");
    end
    rstn = 1'b1;
    tick();
    bif.i_BranchSeq_retire = 1'b0;
    chk("rstw_flush", {31'h0, bif.o_BranchSeq_flush}, 32'h0);
    chk("rstw_state", {30'h0, bif.o_BranchSeq_state}, 32'd0);
    chk("rstw_pc",    bif.o_BranchSeq_pc, 32'h0);
    to_wait(4'b0000, 32'h0000_0004);
    commit(32'h0000_0004, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
